// File: rtl/tlb_walk_arbiter.sv
// Shares the single MMU page-table walker between the I-TLB and the D-TLB.
// Round-robin grant, owner-only response routing, walk watchdog, walk counters.
module tlb_walk_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PERM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  // I-TLB side
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [ADDR_W-1:0] i_resp_addr,
  output logic [PERM_W-1:0] i_resp_perm,
  // D-TLB side
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_resp_valid,
  output logic [ADDR_W-1:0] d_resp_addr,
  output logic [PERM_W-1:0] d_resp_perm,
  // MMU walker
  output logic              mmu_req_valid,
  output logic [ADDR_W-1:0] mmu_req_addr,
  input  logic              mmu_resp_valid,
  input  logic [ADDR_W-1:0] mmu_resp_addr,
  input  logic [PERM_W-1:0] mmu_resp_perm,
  // sfence.vma handshake and status
  input  logic              flush_req,
  output logic              walker_idle,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  i_walk_cnt,
  output logic [CNT_W-1:0]  d_walk_cnt
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  state_e            state_q,         state_d;
  side_e             owner_q,         owner_d;
  side_e             last_grant_q,    last_grant_d;
  logic [WD_W-1:0]   wd_q,            wd_d;
  logic              mmu_req_valid_q, mmu_req_valid_d;
  logic [ADDR_W-1:0] mmu_req_addr_q,  mmu_req_addr_d;
  logic              i_resp_valid_q,  i_resp_valid_d;
  logic [ADDR_W-1:0] i_resp_addr_q,   i_resp_addr_d;
  logic [PERM_W-1:0] i_resp_perm_q,   i_resp_perm_d;
  logic              d_resp_valid_q,  d_resp_valid_d;
  logic [ADDR_W-1:0] d_resp_addr_q,   d_resp_addr_d;
  logic [PERM_W-1:0] d_resp_perm_q,   d_resp_perm_d;
  logic              timeout_err_q,   timeout_err_d;
  logic [CNT_W-1:0]  i_walk_cnt_q,    i_walk_cnt_d;
  logic [CNT_W-1:0]  d_walk_cnt_q,    d_walk_cnt_d;

  logic              pick_d_c;
  logic              any_req_c;
  logic              walk_done_c;
  logic              walk_expired_c;
  logic [ADDR_W-1:0] done_addr_c;
  logic [PERM_W-1:0] done_perm_c;

  // On a tie the side that did not win last time is chosen.
  assign any_req_c = i_req_valid | d_req_valid;
  assign pick_d_c  = d_req_valid & (~i_req_valid | (last_grant_q == SIDE_I));

  // A real response beats a watchdog expiry landing in the same cycle.
  assign walk_done_c    = (state_q == ST_WALK) & mmu_resp_valid;
  assign walk_expired_c = WD_EN & (state_q == ST_WALK) & ~mmu_resp_valid & (wd_q == WD_LAST);
  assign done_addr_c    = walk_done_c ? mmu_resp_addr : '0;
  assign done_perm_c    = walk_done_c ? mmu_resp_perm : '0;

  assign walker_idle = (state_q == ST_IDLE);

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    wd_d            = wd_q;
    mmu_req_valid_d = mmu_req_valid_q;
    mmu_req_addr_d  = mmu_req_addr_q;
    i_resp_valid_d  = 1'b0;
    i_resp_addr_d   = i_resp_addr_q;
    i_resp_perm_d   = i_resp_perm_q;
    d_resp_valid_d  = 1'b0;
    d_resp_addr_d   = d_resp_addr_q;
    d_resp_perm_d   = d_resp_perm_q;
    timeout_err_d   = timeout_err_q;
    i_walk_cnt_d    = i_walk_cnt_q;
    d_walk_cnt_d    = d_walk_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!flush_req && any_req_c) begin
          owner_d         = pick_d_c ? SIDE_D : SIDE_I;
          last_grant_d    = pick_d_c ? SIDE_D : SIDE_I;
          mmu_req_addr_d  = pick_d_c ? d_req_addr : i_req_addr;
          mmu_req_valid_d = 1'b1;
          wd_d            = '0;
          state_d         = ST_WALK;
        end
      end

      ST_WALK: begin
        wd_d = wd_q + WD_W'(1);
        if (walk_done_c || walk_expired_c) begin
          mmu_req_valid_d = 1'b0;
          state_d         = ST_RESP;
          if (walk_expired_c) begin
            timeout_err_d = 1'b1;
          end
          if (owner_q == SIDE_D) begin
            d_resp_valid_d = 1'b1;
            d_resp_addr_d  = done_addr_c;
            d_resp_perm_d  = done_perm_c;
            if (walk_done_c && (d_walk_cnt_q != CNT_MAX)) begin
              d_walk_cnt_d = d_walk_cnt_q + CNT_W'(1);
            end
          end else begin
            i_resp_valid_d = 1'b1;
            i_resp_addr_d  = done_addr_c;
            i_resp_perm_d  = done_perm_c;
            if (walk_done_c && (i_walk_cnt_q != CNT_MAX)) begin
              i_walk_cnt_d = i_walk_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      // Gives the TLB one cycle to drop req_valid before arbitration resumes.
      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= SIDE_I;
      last_grant_q    <= SIDE_I;
      wd_q            <= '0;
      mmu_req_valid_q <= 1'b0;
      mmu_req_addr_q  <= '0;
      i_resp_valid_q  <= 1'b0;
      i_resp_addr_q   <= '0;
      i_resp_perm_q   <= '0;
      d_resp_valid_q  <= 1'b0;
      d_resp_addr_q   <= '0;
      d_resp_perm_q   <= '0;
      timeout_err_q   <= 1'b0;
      i_walk_cnt_q    <= '0;
      d_walk_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      wd_q            <= wd_d;
      mmu_req_valid_q <= mmu_req_valid_d;
      mmu_req_addr_q  <= mmu_req_addr_d;
      i_resp_valid_q  <= i_resp_valid_d;
      i_resp_addr_q   <= i_resp_addr_d;
      i_resp_perm_q   <= i_resp_perm_d;
      d_resp_valid_q  <= d_resp_valid_d;
      d_resp_addr_q   <= d_resp_addr_d;
      d_resp_perm_q   <= d_resp_perm_d;
      timeout_err_q   <= timeout_err_d;
      i_walk_cnt_q    <= i_walk_cnt_d;
      d_walk_cnt_q    <= d_walk_cnt_d;
    end
  end

  assign mmu_req_valid = mmu_req_valid_q;
  assign mmu_req_addr  = mmu_req_addr_q;
  assign i_resp_valid  = i_resp_valid_q;
  assign i_resp_addr   = i_resp_addr_q;
  assign i_resp_perm   = i_resp_perm_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_addr   = d_resp_addr_q;
  assign d_resp_perm   = d_resp_perm_q;
  assign timeout_err   = timeout_err_q;
  assign i_walk_cnt    = i_walk_cnt_q;
  assign d_walk_cnt    = d_walk_cnt_q;

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Directed vector bench for tlb_walk_arbiter: per-cycle stimulus/expectation table
// plus a hand-written asynchronous reset-in-walk sequence.
module tb_tlb_walk_arbiter;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PERM_W  = 8;

  logic              clk;
  logic              reset;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [ADDR_W-1:0] i_resp_addr;
  logic [PERM_W-1:0] i_resp_perm;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_resp_valid;
  logic [ADDR_W-1:0] d_resp_addr;
  logic [PERM_W-1:0] d_resp_perm;
  logic              mmu_req_valid;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic              mmu_resp_valid;
  logic [ADDR_W-1:0] mmu_resp_addr;
  logic [PERM_W-1:0] mmu_resp_perm;
  logic              flush_req;
  logic              walker_idle;
  logic              timeout_err;
  logic [CNT_W-1:0]  i_walk_cnt;
  logic [CNT_W-1:0]  d_walk_cnt;

  tlb_walk_arbiter #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W),
    .PERM_W (PERM_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_resp_valid  (i_resp_valid),
    .i_resp_addr   (i_resp_addr),
    .i_resp_perm   (i_resp_perm),
    .d_req_valid   (d_req_valid),
    .d_req_addr    (d_req_addr),
    .d_resp_valid  (d_resp_valid),
    .d_resp_addr   (d_resp_addr),
    .d_resp_perm   (d_resp_perm),
    .mmu_req_valid (mmu_req_valid),
    .mmu_req_addr  (mmu_req_addr),
    .mmu_resp_valid(mmu_resp_valid),
    .mmu_resp_addr (mmu_resp_addr),
    .mmu_resp_perm (mmu_resp_perm),
    .flush_req     (flush_req),
    .walker_idle   (walker_idle),
    .timeout_err   (timeout_err),
    .i_walk_cnt    (i_walk_cnt),
    .d_walk_cnt    (d_walk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = inputs held across one rising edge + outputs expected just after it.
  typedef struct {
    logic [63:0] rst, ir, ia, dr, da, mv, ma, mp, fl;
    logic [63:0] e_mrv, e_mra, e_irv, e_drv, e_ra, e_rp, e_idle, e_to, e_ic, e_dc;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rec     = 0;
  longint unsigned icm;
  longint unsigned icn;

  task automatic add(input longint unsigned rst, ir, ia, dr, da, mv, ma, mp, fl,
                     input longint unsigned e_mrv, e_mra, e_irv, e_drv, e_ra, e_rp,
                     input longint unsigned e_idle, e_to, e_ic, e_dc);
    vec_t v;
    v.rst = rst;  v.ir = ir;  v.ia = ia;  v.dr = dr;  v.da = da;
    v.mv = mv;    v.ma = ma;  v.mp = mp;  v.fl = fl;
    v.e_mrv = e_mrv; v.e_mra = e_mra; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_ra = e_ra;   v.e_rp = e_rp;   v.e_idle = e_idle; v.e_to = e_to;
    v.e_ic = e_ic;   v.e_dc = e_dc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (record %0d): got %0h, expected %0h", nm, rec, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; d_req_valid = 1'b0; d_req_addr = '0;
    mmu_resp_valid = 1'b0; mmu_resp_addr = '0; mmu_resp_perm = '0; flush_req = 1'b0;

    // reset state
    add(1, 0,0, 0,0, 0,0,0, 0,  0,0, 0,0, 0,0, 1,0, 0,0);
    // single D miss, MMU answers 5 cycles after the grant
    add(0, 0,0, 1,'h8000_1000, 0,0,0, 0,  1,'h8000_1000, 0,0, 0,0, 0,0, 0,0);
    for (int k = 0; k < 4; k++)
      add(0, 0,0, 1,'h8000_1000, 0,0,0, 0,  1,'h8000_1000, 0,0, 0,0, 0,0, 0,0);
    add(0, 0,0, 1,'h8000_1000, 1,'h2000_3000,'h0E, 0,  0,0, 0,1, 'h2000_3000,'h0E, 0,0, 0,1);
    add(0, 0,0, 0,0, 0,0,0, 0,  0,0, 0,0, 0,0, 1,0, 0,1);
    add(0, 0,0, 0,0, 0,0,0, 0,  0,0, 0,0, 0,0, 1,0, 0,1);
    // reset clears the counter; then simultaneous misses alternate D,I,D,I
    add(1, 0,0, 0,0, 0,0,0, 0,  0,0, 0,0, 0,0, 1,0, 0,0);
    add(0, 1,'h1000, 1,'h2000, 0,0,0, 0,      1,'h2000, 0,0, 0,0, 0,0, 0,0);
    add(0, 1,'h1000, 1,'h2000, 1,'hD0,'h0E, 0, 0,0, 0,1, 'hD0,'h0E, 0,0, 0,1);
    add(0, 1,'h1000, 0,0, 0,0,0, 0,           0,0, 0,0, 0,0, 1,0, 0,1);
    add(0, 1,'h1000, 1,'h2100, 0,0,0, 0,      1,'h1000, 0,0, 0,0, 0,0, 0,1);
    add(0, 1,'h1000, 1,'h2100, 1,'h11,'h0B, 0, 0,0, 1,0, 'h11,'h0B, 0,0, 1,1);
    add(0, 0,0, 1,'h2100, 0,0,0, 0,           0,0, 0,0, 0,0, 1,0, 1,1);
    add(0, 1,'h1100, 1,'h2100, 0,0,0, 0,      1,'h2100, 0,0, 0,0, 0,0, 1,1);
    add(0, 1,'h1100, 1,'h2100, 1,'h22,'h0F, 0, 0,0, 0,1, 'h22,'h0F, 0,0, 1,2);
    add(0, 1,'h1100, 0,0, 0,0,0, 0,           0,0, 0,0, 0,0, 1,0, 1,2);
    add(0, 1,'h1100, 1,'h2200, 0,0,0, 0,      1,'h1100, 0,0, 0,0, 0,0, 1,2);
    add(0, 1,'h1100, 1,'h2200, 1,'h12,'h0B, 0, 0,0, 1,0, 'h12,'h0B, 0,0, 2,2);
    add(0, 0,0, 1,'h2200, 0,0,0, 0,           0,0, 0,0, 0,0, 1,0, 2,2);
    add(0, 0,0, 1,'h2200, 0,0,0, 0,           1,'h2200, 0,0, 0,0, 0,0, 2,2);
    add(0, 0,0, 1,'h2200, 1,'h23,'h0E, 0,     0,0, 0,1, 'h23,'h0E, 0,0, 2,3);
    add(0, 0,0, 0,0, 0,0,0, 0,                0,0, 0,0, 0,0, 1,0, 2,3);
    // I back-to-back: old VA still held during RESP is not re-granted; later VA edits ignored
    add(0, 1,'h3000, 0,0, 0,0,0, 0,           1,'h3000, 0,0, 0,0, 0,0, 2,3);
    add(0, 1,'h3000, 0,0, 1,'h31,'h0B, 0,     0,0, 1,0, 'h31,'h0B, 0,0, 3,3);
    add(0, 1,'h3000, 0,0, 0,0,0, 0,           0,0, 0,0, 0,0, 1,0, 3,3);
    add(0, 1,'h3100, 0,0, 0,0,0, 0,           1,'h3100, 0,0, 0,0, 0,0, 3,3);
    add(0, 1,'h3999, 0,0, 0,0,0, 0,           1,'h3100, 0,0, 0,0, 0,0, 3,3);
    add(0, 1,'h3999, 0,0, 1,'h32,'h0B, 0,     0,0, 1,0, 'h32,'h0B, 0,0, 4,3);
    add(0, 0,0, 0,0, 0,0,0, 0,                0,0, 0,0, 0,0, 1,0, 4,3);
    // response arrives on the very cycle the watchdog would expire: response wins
    add(0, 1,'h5000, 0,0, 0,0,0, 0,           1,'h5000, 0,0, 0,0, 0,0, 4,3);
    for (int k = 0; k < 7; k++)
      add(0, 1,'h5000, 0,0, 0,0,0, 0,         1,'h5000, 0,0, 0,0, 0,0, 4,3);
    add(0, 1,'h5000, 0,0, 1,'h51,'h0B, 0,     0,0, 1,0, 'h51,'h0B, 0,0, 5,3);
    add(0, 0,0, 0,0, 0,0,0, 0,                0,0, 0,0, 0,0, 1,0, 5,3);
    // I counter saturates at 7 (3-bit)
    icm = 5;
    for (int k = 0; k < 3; k++) begin
      icn = (icm == 7) ? 7 : icm + 1;
      add(0, 1,'h5100+k, 0,0, 0,0,0, 0,       1,'h5100+k, 0,0, 0,0, 0,0, icm,3);
      add(0, 1,'h5100+k, 0,0, 1,'h60+k,'h0B, 0, 0,0, 1,0, 'h60+k,'h0B, 0,0, icn,3);
      add(0, 0,0, 0,0, 0,0,0, 0,              0,0, 0,0, 0,0, 1,0, icn,3);
      icm = icn;
    end
    // watchdog: MMU silent, fault response on cycle 8, late responses ignored
    add(0, 0,0, 1,'h4000, 0,0,0, 0,           1,'h4000, 0,0, 0,0, 0,0, 7,3);
    for (int k = 0; k < 7; k++)
      add(0, 0,0, 1,'h4000, 0,0,0, 0,         1,'h4000, 0,0, 0,0, 0,0, 7,3);
    add(0, 0,0, 1,'h4000, 0,0,0, 0,           0,0, 0,1, 0,0, 0,1, 7,3);
    add(0, 0,0, 0,0, 1,'hBAD,'h0E, 0,         0,0, 0,0, 0,0, 1,1, 7,3);
    add(0, 0,0, 0,0, 1,'hBAD,'h0E, 0,         0,0, 0,0, 0,0, 1,1, 7,3);
    add(0, 0,0, 0,0, 0,0,0, 0,                0,0, 0,0, 0,0, 1,1, 7,3);
    // flush mid-walk with D waiting: walk completes, D held off until flush drops
    add(0, 1,'h6000, 0,0, 0,0,0, 0,           1,'h6000, 0,0, 0,0, 0,1, 7,3);
    add(0, 1,'h6000, 1,'h7000, 0,0,0, 1,      1,'h6000, 0,0, 0,0, 0,1, 7,3);
    add(0, 1,'h6000, 1,'h7000, 1,'h61,'h0E, 1, 0,0, 1,0, 'h61,'h0E, 0,1, 7,3);
    for (int k = 0; k < 3; k++)
      add(0, 0,0, 1,'h7000, 0,0,0, 1,         0,0, 0,0, 0,0, 1,1, 7,3);
    add(0, 0,0, 1,'h7000, 0,0,0, 0,           1,'h7000, 0,0, 0,0, 0,1, 7,3);
    add(0, 0,0, 1,'h7000, 1,'h71,'h0F, 0,     0,0, 0,1, 'h71,'h0F, 0,1, 7,4);
    add(0, 0,0, 0,0, 0,0,0, 0,                0,0, 0,0, 0,0, 1,1, 7,4);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      cur = vecs[k];
      rec = k;
      reset          = ~cur.rst[0];
      i_req_valid    = cur.ir[0];
      i_req_addr     = cur.ia;
      d_req_valid    = cur.dr[0];
      d_req_addr     = cur.da;
      mmu_resp_valid = cur.mv[0];
      mmu_resp_addr  = cur.ma;
      mmu_resp_perm  = cur.mp[PERM_W-1:0];
      flush_req      = cur.fl[0];
      @(posedge clk);
      #1;
      chk("mmu_req_valid", 64'(mmu_req_valid), cur.e_mrv);
      if (cur.e_mrv[0]) chk("mmu_req_addr", mmu_req_addr, cur.e_mra);
      chk("i_resp_valid", 64'(i_resp_valid), cur.e_irv);
      chk("d_resp_valid", 64'(d_resp_valid), cur.e_drv);
      if (cur.e_irv[0]) begin
        chk("i_resp_addr", i_resp_addr, cur.e_ra);
        chk("i_resp_perm", 64'(i_resp_perm), cur.e_rp);
      end
      if (cur.e_drv[0]) begin
        chk("d_resp_addr", d_resp_addr, cur.e_ra);
        chk("d_resp_perm", 64'(d_resp_perm), cur.e_rp);
      end
      chk("walker_idle", 64'(walker_idle), cur.e_idle);
      chk("timeout_err", 64'(timeout_err), cur.e_to);
      chk("i_walk_cnt", 64'(i_walk_cnt), cur.e_ic);
      chk("d_walk_cnt", 64'(d_walk_cnt), cur.e_dc);
    end

    // Asynchronous reset in the middle of a D walk
    rec = vecs.size();
    i_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 64'h9000;
    mmu_resp_valid = 1'b0; flush_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_grant_valid", 64'(mmu_req_valid), 64'd1);
    chk("rw_grant_addr", mmu_req_addr, 64'h9000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rw_mmu_req_valid", 64'(mmu_req_valid), 64'd0);
    chk("rw_mmu_req_addr", mmu_req_addr, 64'd0);
    chk("rw_d_resp_valid", 64'(d_resp_valid), 64'd0);
    chk("rw_i_resp_valid", 64'(i_resp_valid), 64'd0);
    chk("rw_walker_idle", 64'(walker_idle), 64'd1);
    chk("rw_timeout_err", 64'(timeout_err), 64'd0);
    chk("rw_i_walk_cnt", 64'(i_walk_cnt), 64'd0);
    chk("rw_d_walk_cnt", 64'(d_walk_cnt), 64'd0);
    d_req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mmu_resp_valid = 1'b1; mmu_resp_addr = 64'hAA; mmu_resp_perm = 8'h0E;
    @(posedge clk);
    #1;
    chk("rw_late_d_resp", 64'(d_resp_valid), 64'd0);
    chk("rw_late_i_resp", 64'(i_resp_valid), 64'd0);
    chk("rw_late_d_cnt", 64'(d_walk_cnt), 64'd0);
    chk("rw_late_idle", 64'(walker_idle), 64'd1);
    chk("rw_late_mmu_req", 64'(mmu_req_valid), 64'd0);
    mmu_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_after_d_resp", 64'(d_resp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
